// File: rtl/pipe_skid_reg.sv
// Two-entry (main + skid) pipeline register: 1-cycle accept-to-valid latency, full throughput.
// in_ready is a register output and never depends on out_ready; PIPE_SKID_STATS_EN adds stall_cnt.
module pipe_skid_reg #(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 128,
   parameter int LANES  = 4,
   parameter int PC_W   = 11,
   parameter int TAG_W  = 7,
   parameter int TAGS   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [PC_W-1:0]         in_pc,
   input  logic [TAGS*TAG_W-1:0]   in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [PC_W-1:0]         out_pc,
   output logic [TAGS*TAG_W-1:0]   out_tag
`ifdef PIPE_SKID_STATS_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);

   typedef struct packed {
      logic [CTRL_W-1:0]       ctrl;
      logic [LANES*DATA_W-1:0] data;
      logic [PC_W-1:0]         pc;
      logic [TAGS*TAG_W-1:0]   tag;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_ent;
   logic   ready_q;
   logic   accept, deliver;
   logic   load_main_in, load_main_skid, load_skid;

   assign in_ent   = {in_ctrl, in_data, in_pc, in_tag};
   assign in_ready = ready_q;
   assign accept   = in_valid & ready_q;
   assign out_valid = (state != EMPTY);
   assign deliver  = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main_in = 1'b1;
                  state_nxt    = HALF;
               end
            end
            HALF: begin
               if (accept && deliver) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = FULL;
               end else if (deliver) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (deliver) begin
                  load_main_skid = 1'b1;
                  state_nxt      = HALF;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // ready is registered from the next state so it is low throughout reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != FULL);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)
            main_q <= in_ent;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_ent;
      end
   end

   // ctrl is forced to a bubble when empty; the wide payload just holds
   assign out_ctrl = out_valid ? main_q.ctrl : '0;
   assign out_data = main_q.data;
   assign out_pc   = main_q.pc;
   assign out_tag  = main_q.tag;

`ifdef PIPE_SKID_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (flush)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg with a scoreboard of accepted entries checked at each delivery.
module tb_pipe_skid_reg;

   typedef logic [562:0] ent_t;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [11:0]   in_ctrl;
   logic [511:0]  in_data;
   logic [10:0]   in_pc;
   logic [27:0]   in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [11:0]   out_ctrl;
   logic [511:0]  out_data;
   logic [10:0]   out_pc;
   logic [27:0]   out_tag;
`ifdef PIPE_SKID_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   int   dlv_cnt = 0;
   int   gaps = 0;
   ent_t sb[$];

   pipe_skid_reg dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_pc     (in_pc),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .out_pc    (out_pc),
      .out_tag   (out_tag)
`ifdef PIPE_SKID_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [599:0] got, input logic [599:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i);
      in_valid = 1'b1;
      in_ctrl  = 12'(12'h5A0 + i);
      in_data  = {4{128'(i) + 128'h1000}};
      in_pc    = 11'(i * 3);
      in_tag   = 28'(i * 7 + 1);
   endtask

   // Inputs are stable by the falling edge; whatever handshakes there happens on the next rising edge.
   always @(negedge clk) begin
      ent_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() > 0) e = sb.pop_front();
            else e = 'x;
            chk("deliver", 600'({out_ctrl, out_data, out_pc, out_tag}), 600'(e));
            dlv_cnt++;
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data, in_pc, in_tag});
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0; in_pc = '0; in_tag = '0;
      #1;
      chk("rst_in_ready", 600'(in_ready), 600'(0));
      chk("rst_out_valid", 600'(out_valid), 600'(0));
      chk("rst_out_ctrl", 600'(out_ctrl), 600'(0));
      chk("rst_out_data", 600'(out_data), 600'(0));
      step();
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", 600'(in_ready), 600'(1));

      // single entry, 1-cycle latency
      in_valid = 1'b1; in_ctrl = 12'hABC; in_data = 512'h1; in_pc = 11'h12; in_tag = 28'h55;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      chk("lat_out_valid", 600'(out_valid), 600'(1));
      chk("lat_out_ctrl", 600'(out_ctrl), 600'(12'hABC));
      chk("lat_lane0", 600'(out_data[127:0]), 600'(1));
      step();
      chk("drain1_valid", 600'(out_valid), 600'(0));
      chk("bubble_ctrl", 600'(out_ctrl), 600'(0));

      // fill to FULL, then drain A then B
      out_ready = 1'b0;
      put(1); step();
      put(2); step();
      in_valid = 1'b0;
      chk("full_in_ready", 600'(in_ready), 600'(0));
      chk("full_head_ctrl", 600'(out_ctrl), 600'(12'h5A1));
      out_ready = 1'b1;
      step();
      chk("half_in_ready", 600'(in_ready), 600'(1));
      chk("half_head_ctrl", 600'(out_ctrl), 600'(12'h5A2));
      step();
      chk("empty_valid", 600'(out_valid), 600'(0));
      chk("empty_in_ready", 600'(in_ready), 600'(1));
      chk("empty_sb", 600'(sb.size()), 600'(0));

      // 100 entries streamed back to back
      dlv_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         put(100 + i);
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b1) gaps++;
      end
      in_valid = 1'b0;
      step();
      chk("stream_gaps", 600'(gaps), 600'(0));
      chk("stream_count", 600'(dlv_cnt), 600'(100));
      chk("stream_sb", 600'(sb.size()), 600'(0));

      // flush while FULL drops held entries and the offered one
      out_ready = 1'b0;
      put(300); step();
      put(301); step();
      put(302); flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_valid", 600'(out_valid), 600'(0));
      chk("flush_ctrl", 600'(out_ctrl), 600'(0));
      chk("flush_in_ready", 600'(in_ready), 600'(1));
      step(); step();
      chk("flush_no_replay", 600'(out_valid), 600'(0));

      // deliver in the flush cycle is consumed exactly once
      put(400); step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_dlv_valid", 600'(out_valid), 600'(0));
      step();
      chk("flush_dlv_no_replay", 600'(out_valid), 600'(0));

      // asynchronous reset between edges while HALF
      out_ready = 1'b0;
      put(500); step();
      in_valid = 1'b0;
      chk("pre_arst_valid", 600'(out_valid), 600'(1));
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 600'(out_valid), 600'(0));
      chk("arst_ctrl", 600'(out_ctrl), 600'(0));
      chk("arst_data", 600'(out_data), 600'(0));
      chk("arst_pc", 600'(out_pc), 600'(0));
      chk("arst_tag", 600'(out_tag), 600'(0));
      chk("arst_in_ready", 600'(in_ready), 600'(0));
      #1 reset = 1'b0;
      sb.delete();
      out_ready = 1'b1;
      step();
      chk("post_arst_valid", 600'(out_valid), 600'(0));
      chk("post_arst_in_ready", 600'(in_ready), 600'(1));

`ifdef PIPE_SKID_STATS_EN
      out_ready = 1'b0;
      put(600); step();
      in_valid = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      chk("stall_sat", 600'(stall_cnt), 600'(16'hFFFF));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("stall_flush", 600'(stall_cnt), 600'(0));
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
